// File: rtl/arch_regfile_if.sv
// Writeback-to-regfile retirement channel.
// The writeback stage (master) presents one retiring instruction per cycle
// under a valid/ready handshake; the architectural regfile (slave) accepts it.
interface arch_regfile_if #(
  parameter int XLEN = 64
) ();

  logic            wb_valid;
  logic            wb_ready;
  logic            wb_wen;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] wb_next_pc;
  logic            wb_halt;

  modport master (
    output wb_valid, wb_wen, wb_rd, wb_data, wb_next_pc, wb_halt,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_wen, wb_rd, wb_data, wb_next_pc, wb_halt,
    output wb_ready
  );

endinterface

// File: rtl/arch_regfile.sv
// Architectural state of the single-cycle RV64 core: 32 x XLEN GPRs plus the
// committed PC. Retires one instruction per cycle from writeback, serves two
// combinational read ports, exposes the flattened state bus for difftest,
// counts commits and latches the halt (ebreak) condition and exit code.
//
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write to
// the read ports (write-through). gpr_flat is never bypassed.
module arch_regfile #(
  parameter int              XLEN     = 64,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                     clock,
  input  logic                     reset,        // async, active low
  arch_regfile_if.slave            wb,
  input  logic [4:0]               rs1_addr,
  output logic [XLEN-1:0]          rs1_data,
  input  logic [4:0]               rs2_addr,
  output logic [XLEN-1:0]          rs2_data,
  output logic [(NREG+1)*XLEN-1:0] gpr_flat,
  output logic                     commit_valid,
  output logic [63:0]              commit_count,
  output logic                     halted,
  output logic [XLEN-1:0]          halt_code
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  state_e          state_q;
  logic            ready_q;
  logic [XLEN-1:0] gpr_q [NREG];
  logic [XLEN-1:0] pc_q;
  logic [63:0]     count_q;
  logic [63:0]     count_d;
  logic            commit_q;
  logic            halted_q;
  logic [XLEN-1:0] halt_code_q;
  logic [XLEN-1:0] halt_code_d;

  logic            fire;
  logic            do_wr;

  // ready is a registered FSM output, so fire never depends on a comb path
  assign fire     = wb.wb_valid & ready_q;
  // x0 is hard-wired: a write addressed to it is dropped here
  assign do_wr    = fire & wb.wb_wen & (wb.wb_rd != 5'd0);
  assign count_d  = count_q + 64'd1;
  // a0 as it will be after this retirement, captured as the exit code on ebreak
  assign halt_code_d = (wb.wb_wen && (wb.wb_rd == 5'd10)) ? wb.wb_data : gpr_q[10];

  assign wb.wb_ready  = ready_q;
  assign commit_valid = commit_q;
  assign commit_count = count_q;
  assign halted       = halted_q;
  assign halt_code    = halt_code_q;

  // Retirement FSM: RUN accepts commits, HALT freezes all state until reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      ready_q     <= 1'b1;
      pc_q        <= RESET_PC;
      count_q     <= '0;
      commit_q    <= 1'b0;
      halted_q    <= 1'b0;
      halt_code_q <= '0;
      // NOTE: the GPR array is reset here on purpose; architectural state must
      // read as zero straight after reset, so this cannot map to a plain RAM.
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees pre-edge state (e.g. halt_code_d reads the old x10).
      commit_q <= fire;
      case (state_q)
        ST_RUN: begin
          if (fire) begin
            pc_q    <= wb.wb_next_pc;
            count_q <= count_d;
            if (do_wr) begin
              gpr_q[wb.wb_rd] <= wb.wb_data;
            end
            if (wb.wb_halt) begin
              state_q     <= ST_HALT;
              ready_q     <= 1'b0;
              halted_q    <= 1'b1;
              halt_code_q <= halt_code_d;
            end
          end
        end
        ST_HALT: begin
          ready_q <= 1'b0;
        end
        default: begin
          state_q <= ST_HALT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Combinational read ports with optional same-cycle write-through
  always_comb begin
    // NOTE: both outputs get a value before any conditional override, so no
    // latch is inferred whichever branches are taken.
    rs1_data = (rs1_addr == 5'd0) ? '0 : gpr_q[rs1_addr];
    rs2_data = (rs2_addr == 5'd0) ? '0 : gpr_q[rs2_addr];
    if (BYPASS && do_wr && (rs1_addr == wb.wb_rd)) begin
      rs1_data = wb.wb_data;
    end
    if (BYPASS && do_wr && (rs2_addr == wb.wb_rd)) begin
      rs2_data = wb.wb_data;
    end
  end

  // Difftest state bus: stored GPRs (slice 0 forced to zero), then the PC
  always_comb begin
    gpr_flat = '0;
    for (int k = 1; k < NREG; k++) begin
      gpr_flat[k*XLEN +: XLEN] = gpr_q[k];
    end
    gpr_flat[NREG*XLEN +: XLEN] = pc_q;
  end

endmodule

// File: tb/tb_arch_regfile.sv
// Directed self-checking bench for arch_regfile: reset, basic retirement,
// x0 protection, read ports, same-cycle read (bypass build aware), halt,
// reset out of HALT, asynchronous reset mid-run, and halt without an a0 write.
module tb_arch_regfile;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

`ifdef REGFILE_BYPASS_EN
  localparam logic [63:0] SAME_CYCLE_RS1 = 64'hA5A5;
`else
  localparam logic [63:0] SAME_CYCLE_RS1 = 64'h0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic [4:0]               rs1_addr, rs2_addr;
  logic [XLEN-1:0]          rs1_data, rs2_data;
  logic [(NREG+1)*XLEN-1:0] gpr_flat;
  logic                     commit_valid;
  logic [63:0]              commit_count;
  logic                     halted;
  logic [XLEN-1:0]          halt_code;

  arch_regfile_if #(.XLEN(XLEN)) wb_if ();

  arch_regfile #(
    .XLEN(XLEN), .NREG(NREG), .RESET_PC(RST_PC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wb           (wb_if),
    .rs1_addr     (rs1_addr),
    .rs1_data     (rs1_data),
    .rs2_addr     (rs2_addr),
    .rs2_data     (rs2_data),
    .gpr_flat     (gpr_flat),
    .commit_valid (commit_valid),
    .commit_count (commit_count),
    .halted       (halted),
    .halt_code    (halt_code)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_gpr [NREG];
  logic [63:0] exp_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] slice(input int k);
    return gpr_flat[k*XLEN +: XLEN];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) exp_gpr[i] = '0;
    exp_pc = RST_PC;
  endtask

  task automatic check_flat(input string tag);
    for (int k = 0; k < NREG; k++) begin
      check($sformatf("%s gpr_flat[%0d]", tag, k), slice(k), exp_gpr[k]);
    end
    check($sformatf("%s gpr_flat[pc]", tag), slice(NREG), exp_pc);
  endtask

  task automatic set_wb(input logic v, input logic wen, input logic [4:0] rd,
                        input logic [63:0] data, input logic [63:0] npc, input logic hlt);
    @(negedge clock);
    wb_if.wb_valid   = v;
    wb_if.wb_wen     = wen;
    wb_if.wb_rd      = rd;
    wb_if.wb_data    = data;
    wb_if.wb_next_pc = npc;
    wb_if.wb_halt    = hlt;
  endtask

  // One accepted retirement; returns 1 time unit after the capturing edge
  task automatic commit(input logic wen, input logic [4:0] rd, input logic [63:0] data,
                        input logic [63:0] npc, input logic hlt);
    set_wb(1'b1, wen, rd, data, npc, hlt);
    @(posedge clock);
    #1;
    wb_if.wb_valid = 1'b0;
    wb_if.wb_halt  = 1'b0;
    if (wen && rd != 5'd0) exp_gpr[rd] = data;
    exp_pc = npc;
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    wb_if.wb_valid = 1'b0;
    wb_if.wb_wen = 1'b0;
    wb_if.wb_rd = '0;
    wb_if.wb_data = '0;
    wb_if.wb_next_pc = '0;
    wb_if.wb_halt = 1'b0;
    model_reset();

    // Reset held for 3 cycles, then released
    repeat (3) @(posedge clock);
    #1;
    check("in reset commit_count", commit_count, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_flat("reset");
    check("reset commit_count", commit_count, 64'd0);
    check("reset wb_ready", {63'd0, wb_if.wb_ready}, 64'd1);
    check("reset halted", {63'd0, halted}, 64'd0);
    check("reset commit_valid", {63'd0, commit_valid}, 64'd0);
    check("reset halt_code", halt_code, 64'd0);

    // Basic write
    commit(1'b1, 5'd5, 64'hDEAD_BEEF, 64'h8000_0004, 1'b0);
    check("basic gpr5", slice(5), 64'hDEAD_BEEF);
    check("basic pc", slice(NREG), 64'h8000_0004);
    check("basic commit_valid", {63'd0, commit_valid}, 64'd1);
    check("basic commit_count", commit_count, 64'd1);
    rs1_addr = 5'd5;
    #1;
    check("basic rs1 read", rs1_data, 64'hDEAD_BEEF);
    idle();
    check("commit_valid drops", {63'd0, commit_valid}, 64'd0);
    check("count holds idle", commit_count, 64'd1);

    // x0 protection
    commit(1'b1, 5'd0, 64'h1234, 64'h8000_0008, 1'b0);
    check("x0 slice0", slice(0), 64'd0);
    rs1_addr = 5'd0;
    #1;
    check("x0 rs1 read", rs1_data, 64'd0);
    check("x0 commit_count", commit_count, 64'd2);
    check_flat("x0");

    // Both ports on the same register
    rs1_addr = 5'd5;
    rs2_addr = 5'd5;
    #1;
    check("same reg rs1", rs1_data, 64'hDEAD_BEEF);
    check("same reg rs2", rs2_data, 64'hDEAD_BEEF);

    // Same-cycle read of the register being written
    set_wb(1'b1, 1'b1, 5'd7, 64'hA5A5, 64'h8000_000C, 1'b0);
    rs1_addr = 5'd7;
    rs2_addr = 5'd5;
    #1;
    check("same-cycle rs1", rs1_data, SAME_CYCLE_RS1);
    check("same-cycle rs2 other reg", rs2_data, 64'hDEAD_BEEF);
    check("same-cycle flat not bypassed", slice(7), 64'd0);
    @(posedge clock);
    #1;
    wb_if.wb_valid = 1'b0;
    exp_gpr[7] = 64'hA5A5;
    exp_pc = 64'h8000_000C;
    check("next-cycle rs1", rs1_data, 64'hA5A5);
    check("next-cycle gpr7", slice(7), 64'hA5A5);
    check("bypass commit_count", commit_count, 64'd3);

    // Nonzero a0 first, so the halt test distinguishes new a0 from old
    commit(1'b1, 5'd10, 64'h99, 64'h8000_0010, 1'b0);
    check("a0 preload", slice(10), 64'h99);

    // Halt writing a0 = 0
    commit(1'b1, 5'd10, 64'h0, 64'h8000_0014, 1'b1);
    check("halt halted", {63'd0, halted}, 64'd1);
    check("halt halt_code", halt_code, 64'd0);
    check("halt wb_ready", {63'd0, wb_if.wb_ready}, 64'd0);
    check("halt commit_count", commit_count, 64'd5);
    check("halt commit_valid", {63'd0, commit_valid}, 64'd1);
    check("halt gpr10", slice(10), 64'd0);

    // Retirement offered while halted is ignored
    set_wb(1'b1, 1'b1, 5'd3, 64'h77, 64'h8000_0100, 1'b0);
    @(posedge clock);
    #1;
    wb_if.wb_valid = 1'b0;
    check("halted gpr3", slice(3), 64'd0);
    check("halted commit_count", commit_count, 64'd5);
    check("halted commit_valid", {63'd0, commit_valid}, 64'd0);
    check("halted still halted", {63'd0, halted}, 64'd1);
    check_flat("halted hold");

    // Reset out of HALT
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    check("halt reset halted", {63'd0, halted}, 64'd0);
    check("halt reset wb_ready", {63'd0, wb_if.wb_ready}, 64'd1);
    check("halt reset commit_count", commit_count, 64'd0);
    check("halt reset halt_code", halt_code, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Ten commits, then asynchronous reset between clock edges
    commit(1'b1, 5'd1, 64'h55, 64'h8000_0004, 1'b0);
    for (int i = 2; i <= 10; i++) begin
      commit(1'b1, 5'd2, 64'(i), 64'h8000_0000 + 64'(4 * i), 1'b0);
    end
    check("run commit_count", commit_count, 64'd10);
    check("run gpr1", slice(1), 64'h55);
    check("run gpr2", slice(2), 64'd10);
    check("run commit_valid", {63'd0, commit_valid}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async commit_count", commit_count, 64'd0);
    check("async commit_valid", {63'd0, commit_valid}, 64'd0);
    check("async wb_ready", {63'd0, wb_if.wb_ready}, 64'd1);
    check("async halted", {63'd0, halted}, 64'd0);
    check_flat("async");
    @(negedge clock);
    reset = 1'b1;

    // Halt without writing a0: exit code is the current x10
    commit(1'b1, 5'd10, 64'h42, 64'h8000_0004, 1'b0);
    commit(1'b0, 5'd3, 64'h77, 64'h8000_0008, 1'b1);
    check("halt2 halted", {63'd0, halted}, 64'd1);
    check("halt2 halt_code", halt_code, 64'h42);
    check("halt2 gpr3", slice(3), 64'd0);
    check("halt2 commit_count", commit_count, 64'd2);
    check("halt2 pc", slice(NREG), 64'h8000_0008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arch_regfile.md
Name: arch_regfile

Overview:
- Architectural state holder for the single-cycle RV64 core: 32 x 64-bit GPRs plus the committed PC.
- Accepts one retiring instruction per cycle from the writeback stage over a valid/ready handshake.
- Serves two combinational read ports to decode/execute.
- Drives the flattened 33-entry state bus (GPR 0..31, then PC) that the difftest bridge consumes; also counts commits and handles halt (ebreak).

Parameters:
- XLEN, 64, data width of every GPR and the PC.
- NREG, 32, number of GPRs; x0 hard-wired to zero.
- RESET_PC, 64'h8000_0000, PC value loaded on reset.

Ports:
- clock  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (low = in reset)
- wb_valid  in  1  writeback stage presents a retiring instruction
- wb_ready  out  1  block can accept a retirement this cycle
- wb_wen  in  1  retiring instruction writes rd
- wb_rd  in  5  destination register index
- wb_data  in  XLEN  value written to rd
- wb_next_pc  in  XLEN  PC of the next instruction after this retirement
- wb_halt  in  1  retiring instruction is ebreak
- rs1_addr  in  5  read port 1 index
- rs1_data  out  XLEN  read port 1 data
- rs2_addr  in  5  read port 2 index
- rs2_data  out  XLEN  read port 2 data
- gpr_flat  out  (NREG+1)*XLEN  slice k = GPR k for k<32, slice 32 = committed PC
- commit_valid  out  1  one-cycle pulse: gpr_flat reflects a new retirement
- commit_count  out  64  number of retired instructions
- halted  out  1  core has executed ebreak
- halt_code  out  XLEN  value of a0 (x10) after the halting instruction

Behaviour:
- Reset (reset low, async):
  - all GPRs = 0; PC = RESET_PC; commit_count = 0; commit_valid = 0; halted = 0; halt_code = 0; state = RUN.
  - Releasing reset takes effect at the next rising edge.
  - Reset asserted mid-run or in HALT clears everything immediately; any in-flight handshake is discarded.
- States: RUN, HALT.
  - RUN: wb_ready = 1. HALT: wb_ready = 0; nothing changes except through reset.
- fire = wb_valid & wb_ready. On a rising edge with fire:
  - if wb_wen and wb_rd != 0: GPR[wb_rd] <= wb_data. Writes to x0 are dropped.
  - PC <= wb_next_pc.
  - commit_count <= commit_count + 1, wrapping modulo 2^64.
  - commit_valid <= 1 for exactly the next cycle; otherwise commit_valid <= 0.
  - if wb_halt: state <= HALT; halted <= 1; halt_code <= new a0 (wb_data if wb_wen and wb_rd == 10, else the current x10).
- Latency: a write is visible on gpr_flat, commit_count and the read ports (stored path) one cycle after fire. commit_valid rises in that same cycle, so the difftest sampler sees consistent state.
- wb_valid with wb_ready = 0 (HALT): ignored, no state change.
- Reads are combinational. Index 0 returns 0. Both ports may address the same register.
- gpr_flat slice 0 is always 0.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: if fire & wb_wen & wb_rd != 0 & rsN_addr == wb_rd, rsN_data = wb_data in the same cycle (write-through). gpr_flat is never bypassed.
- Undefined: read ports return stored values only; the same-cycle write is seen one cycle later.

Test Plan:
- Reset check: hold reset low 3 cycles, release -> gpr_flat all 0 except slice 32 = 64'h8000_0000; commit_count 0; wb_ready 1; halted 0.
- Basic write: fire wen=1 rd=5 data=64'hDEAD_BEEF next_pc=64'h8000_0004 -> next cycle GPR5 = DEAD_BEEF, PC = 8000_0004, commit_valid high 1 cycle, commit_count = 1.
- x0 protection: fire wen=1 rd=0 data=64'h1234 -> slice 0 stays 0; rs1_addr=0 reads 0; commit_count still increments.
- Bypass: rs1_addr=7 while firing rd=7 data=64'hA5A5 -> with REGFILE_BYPASS_EN, rs1_data=A5A5 same cycle; without it, rs1_data = old value (0), then A5A5 next cycle.
- Halt: fire wb_halt=1 wen=1 rd=10 data=64'h0 -> halted=1, halt_code=0, wb_ready=0. A following wb_valid with rd=3 data=64'h77 -> GPR3 unchanged, commit_count unchanged.
- Async reset mid-run: after 10 commits with x1 = 64'h55, assert reset between clock edges -> all outputs return to reset values immediately, without waiting for a clock edge.
